master_port: RTL and testbench
==============================

Name: master_port

Overview:
- Bus-side master interface sitting directly downstream of the master core.
- Accepts the core's parallel address, write, read and force requests.
- Arbitrates for the shared system bus and serialises the 16-bit address frame and 8-bit write data MSB-first onto the bus.
- Deserialises 8-bit read data from the slave and returns ok/done handshakes to the core.
- One instance per bus master; bus-side ports connect to the arbiter and the slave mux.

Parameters:
ADDR_WIDTH, 16, address frame width: {start bit, slave[1:0], rw, addr[11:0]}
DATA_WIDTH, 8, data byte width
ACK_TIMEOUT, 8'd20, cycles to wait for s_ack or first s_rx_valid before retrying
HOLD_TIMEOUT, 8'd8, cycles the bus is held after force_req awaiting the next address request

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
addr_from_core  input  16  address frame, valid while write_addr_req_from_core high
write_addr_req_from_core  input  1  address phase request (level)
write_data_from_core  input  8  write byte, valid while write_data_req_from_core high
write_data_req_from_core  input  1  write data phase request (level)
read_data_req_from_core  input  1  read data phase request (level)
force_req_from_core  input  1  keep bus ownership for next transfer
ok_response_to_core  output  1  address accepted; held until address request drops
read_data_to_core  output  8  read byte, valid while req_done_to_core high
req_done_to_core  output  1  data phase complete; held until data request drops
bus_req  output  1  request to arbiter
bus_grant  input  1  grant from arbiter
m_tx  output  1  serial line to slave, idles 0
m_tx_valid  output  1  high on every cycle a bit is driven on m_tx
s_ack  input  1  one-cycle slave acknowledge
s_rx  input  1  serial read data from slave
s_rx_valid  input  1  high on each valid s_rx bit

Behaviour:
- Clocking and reset: one clock, posedge clk; reset is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, counters 0, latched address/data 0.
- Reset mid-transfer aborts immediately; bus_req drops asynchronously.
- IDLE: on write_addr_req_from_core=1, latch addr_from_core, set bus_req=1, go to ARB.
- ARB: on bus_grant=1, go to ADDR_TX.
- ADDR_TX: 16 cycles.
  - Drive latched addr[15-i] on m_tx with m_tx_valid=1, i=0..15.
  - Bit 15, the start bit, is always sent first.
- ADDR_ACK: count up to ACK_TIMEOUT.
  - s_ack=1 → ok_response_to_core=1, go to ADDR_OK.
  - Timeout → retry: bus_req=0 for one cycle, then back to ARB. Latched address is reused.
- ADDR_OK: when write_addr_req_from_core=0, clear ok_response_to_core and go to DATA_WAIT.
- DATA_WAIT: select the data phase.
  - write_data_req_from_core=1 → latch byte, go to WDATA_TX.
  - read_data_req_from_core=1 → go to RDATA_RX.
  - Both high: write wins.
- WDATA_TX: 8 cycles, MSB first, then WDATA_ACK.
  - WDATA_ACK timeout behaves as ADDR_ACK timeout, then the full address frame is resent.
  - On s_ack=1 → DONE.
- RDATA_RX: shift s_rx in MSB-first on each s_rx_valid=1.
  - s_rx_valid dropping mid-byte discards the partial byte and restarts the bit count.
  - No first bit within ACK_TIMEOUT cycles → retry from ARB.
  - After 8 bits, load read_data_to_core and go to DONE.
- DONE:
  - Assert req_done_to_core.
  - When the data request drops, clear req_done_to_core and go to RELEASE_CHK.
  - read_data_to_core keeps its last value.
- RELEASE_CHK (1 cycle):
  - If force_req_from_core was 1 in this cycle or the previous cycle → HOLD; bus_req stays 1.
  - Else bus_req=0 → IDLE.
- HOLD: bus_req stays 1, count to HOLD_TIMEOUT.
  - write_addr_req_from_core=1 → latch address, go to ADDR_TX (no re-arbitration) if bus_grant still 1, else ARB.
  - Timeout → bus_req=0 → IDLE.
- Grant loss: bus_grant=0 in any state from ADDR_TX through RDATA_RX aborts the phase.
  - Clear m_tx_valid and go to ARB.
  - The transfer restarts from the address frame; the core's level requests remain valid.
- Handshake latencies:
  - ok_response_to_core: 16 cycles after grant plus slave ack latency.
  - req_done_to_core: no earlier than 9 cycles after the data request is seen.

Optional Feature:
- Macro MASTER_PORT_PARITY_EN.
- When defined:
  - An even-parity bit is appended after the address frame (17 cycles) and after write data (9 cycles).
  - Read frames are 9 bits; the 9th bit is checked.
  - On mismatch, sticky output parity_err_to_core (1 bit, cleared only by reset) is set and the byte is still delivered.
- When undefined: no parity bits; parity_err_to_core port absent.

Test Plan:
- Single write: addr 16'hB190 and data 8'hAA, grant after 3 cycles, s_ack 2 cycles after each frame.
  - Required: m_tx carries 1011000110010000 then 10101010.
  - ok_response_to_core rises 1 cycle after the first s_ack; req_done_to_core rises 1 cycle after the second; bus_req drops.
- Read: addr 16'hA190; slave returns 8'h9B over 8 s_rx_valid cycles.
  - Required: read_data_to_core=8'h9B while req_done_to_core=1.
- Burst with force: two writes to 16'hD3E8/16'hD3E9, data 8'h91/8'h96, force_req_from_core pulsed between them.
  - Required: bus_req stays high throughout; second address frame starts without a new ARB wait.
- Timeout retry: no s_ack after the address frame.
  - Required: after 20 cycles bus_req=0 for 1 cycle, then high, and the same frame is resent.
- Grant loss: bus_grant dropped at bit 5 of the address frame, restored 4 cycles later.
  - Required: full 16-bit frame resent from bit 15; transfer completes normally.
- Reset asserted during WDATA_TX.
  - Required: all outputs 0 immediately; a subsequent write completes correctly.

Source files
------------

// File: rtl/master_port.sv
// Bus-side master port: arbitrates for the shared bus, serialises address/write frames MSB-first
// and deserialises read bytes. Define MASTER_PORT_PARITY_EN for even-parity bits and parity_err_to_core.
module master_port #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter logic [7:0]  ACK_TIMEOUT  = 8'd20,
  parameter logic [7:0]  HOLD_TIMEOUT = 8'd8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_from_core,
  input  logic                  write_addr_req_from_core,
  input  logic [DATA_WIDTH-1:0] write_data_from_core,
  input  logic                  write_data_req_from_core,
  input  logic                  read_data_req_from_core,
  input  logic                  force_req_from_core,
  output logic                  ok_response_to_core,
  output logic [DATA_WIDTH-1:0] read_data_to_core,
  output logic                  req_done_to_core,
`ifdef MASTER_PORT_PARITY_EN
  output logic                  parity_err_to_core,
`endif
  output logic                  bus_req,
  input  logic                  bus_grant,
  output logic                  m_tx,
  output logic                  m_tx_valid,
  input  logic                  s_ack,
  input  logic                  s_rx,
  input  logic                  s_rx_valid
);

`ifdef MASTER_PORT_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned FW  = ADDR_WIDTH + PAR;
  localparam int unsigned RXW = DATA_WIDTH - 1 + PAR;
  localparam logic [4:0] ADDR_LAST = 5'(ADDR_WIDTH + PAR - 1);
  localparam logic [4:0] DATA_LAST = 5'(DATA_WIDTH + PAR - 1);

  typedef enum logic [3:0] {
    IDLE, ARB, ADDR_TX, ADDR_ACK, ADDR_OK, DATA_WAIT, WDATA_TX,
    WDATA_ACK, RDATA_RX, DONE, RELEASE_CHK, HOLD, RETRY
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [FW-1:0]         tx_sh, tx_n;
  logic [RXW-1:0]        rx_sh, rx_n;
  logic [4:0]            bit_cnt, cnt_n;
  logic [7:0]            timer, timer_n;
  logic [DATA_WIDTH-1:0] rd_n;
  logic                  ok_n, done_n, breq_n, force_prev, grant_lost;
`ifdef MASTER_PORT_PARITY_EN
  logic                  perr_n;
`endif

  // Both frames share one MSB-aligned shifter; the parity bit (if any) sits right after the payload.
  function automatic logic [FW-1:0] addr_frame(input logic [ADDR_WIDTH-1:0] a);
`ifdef MASTER_PORT_PARITY_EN
    return {a, ^a};
`else
    return a;
`endif
  endfunction

  function automatic logic [FW-1:0] data_frame(input logic [DATA_WIDTH-1:0] d);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1 -: DATA_WIDTH] = d;
`ifdef MASTER_PORT_PARITY_EN
    f[FW-1-DATA_WIDTH] = ^d;
`endif
    return f;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      addr_q              <= '0;
      tx_sh               <= '0;
      rx_sh               <= '0;
      bit_cnt             <= '0;
      timer               <= '0;
      read_data_to_core   <= '0;
      ok_response_to_core <= 1'b0;
      req_done_to_core    <= 1'b0;
      bus_req             <= 1'b0;
      force_prev          <= 1'b0;
`ifdef MASTER_PORT_PARITY_EN
      parity_err_to_core  <= 1'b0;
`endif
    end else begin
      state               <= state_n;
      addr_q              <= addr_n;
      tx_sh               <= tx_n;
      rx_sh               <= rx_n;
      bit_cnt             <= cnt_n;
      timer               <= timer_n;
      read_data_to_core   <= rd_n;
      ok_response_to_core <= ok_n;
      req_done_to_core    <= done_n;
      bus_req             <= breq_n;
      force_prev          <= force_req_from_core;
`ifdef MASTER_PORT_PARITY_EN
      parity_err_to_core  <= perr_n;
`endif
    end
  end

  assign grant_lost = !bus_grant &&
    (state inside {ADDR_TX, ADDR_ACK, ADDR_OK, DATA_WAIT, WDATA_TX, WDATA_ACK, RDATA_RX});

  always_comb begin
    state_n    = state;
    addr_n     = addr_q;
    tx_n       = tx_sh;
    rx_n       = rx_sh;
    cnt_n      = bit_cnt;
    timer_n    = timer;
    rd_n       = read_data_to_core;
    ok_n       = ok_response_to_core;
    done_n     = req_done_to_core;
    breq_n     = bus_req;
    m_tx       = 1'b0;
    m_tx_valid = 1'b0;
`ifdef MASTER_PORT_PARITY_EN
    perr_n     = parity_err_to_core;
`endif
    if (grant_lost) begin
      // Restart from the address frame; the core's level requests are still up.
      state_n = ARB;
      ok_n    = 1'b0;
      cnt_n   = '0;
      timer_n = '0;
    end else begin
      case (state)
        IDLE: if (write_addr_req_from_core) begin
          addr_n  = addr_from_core;
          breq_n  = 1'b1;
          state_n = ARB;
        end
        ARB: if (bus_grant) begin
          tx_n    = addr_frame(addr_q);
          cnt_n   = '0;
          state_n = ADDR_TX;
        end
        ADDR_TX: begin
          m_tx       = tx_sh[FW-1];
          m_tx_valid = 1'b1;
          tx_n       = {tx_sh[FW-2:0], 1'b0};
          if (bit_cnt == ADDR_LAST) begin
            cnt_n   = '0;
            timer_n = '0;
            state_n = ADDR_ACK;
          end else cnt_n = bit_cnt + 5'd1;
        end
        ADDR_ACK: begin
          if (s_ack) begin
            ok_n    = 1'b1;
            state_n = ADDR_OK;
          end else if (timer == ACK_TIMEOUT - 8'd1) begin
            breq_n  = 1'b0;
            state_n = RETRY;
          end else timer_n = timer + 8'd1;
        end
        ADDR_OK: if (!write_addr_req_from_core) begin
          ok_n    = 1'b0;
          state_n = DATA_WAIT;
        end
        DATA_WAIT: begin
          if (write_data_req_from_core) begin
            tx_n    = data_frame(write_data_from_core);
            cnt_n   = '0;
            state_n = WDATA_TX;
          end else if (read_data_req_from_core) begin
            rx_n    = '0;
            cnt_n   = '0;
            timer_n = '0;
            state_n = RDATA_RX;
          end
        end
        WDATA_TX: begin
          m_tx       = tx_sh[FW-1];
          m_tx_valid = 1'b1;
          tx_n       = {tx_sh[FW-2:0], 1'b0};
          if (bit_cnt == DATA_LAST) begin
            cnt_n   = '0;
            timer_n = '0;
            state_n = WDATA_ACK;
          end else cnt_n = bit_cnt + 5'd1;
        end
        WDATA_ACK: begin
          if (s_ack) begin
            done_n  = 1'b1;
            state_n = DONE;
          end else if (timer == ACK_TIMEOUT - 8'd1) begin
            breq_n  = 1'b0;
            state_n = RETRY;
          end else timer_n = timer + 8'd1;
        end
        RDATA_RX: begin
          if (s_rx_valid) begin
            timer_n = '0;
            if (bit_cnt == DATA_LAST) begin
`ifdef MASTER_PORT_PARITY_EN
              rd_n = rx_sh;
              if ((^rx_sh) != s_rx) perr_n = 1'b1;
`else
              rd_n = {rx_sh, s_rx};
`endif
              done_n  = 1'b1;
              state_n = DONE;
            end else begin
              rx_n  = {rx_sh[RXW-2:0], s_rx};
              cnt_n = bit_cnt + 5'd1;
            end
          end else if (bit_cnt != 5'd0) begin
            cnt_n   = '0;
            timer_n = '0;
          end else if (timer == ACK_TIMEOUT - 8'd1) begin
            breq_n  = 1'b0;
            state_n = RETRY;
          end else timer_n = timer + 8'd1;
        end
        DONE: if (!write_data_req_from_core && !read_data_req_from_core) begin
          done_n  = 1'b0;
          state_n = RELEASE_CHK;
        end
        RELEASE_CHK: begin
          if (force_req_from_core || force_prev) begin
            timer_n = '0;
            state_n = HOLD;
          end else begin
            breq_n  = 1'b0;
            state_n = IDLE;
          end
        end
        HOLD: begin
          if (write_addr_req_from_core) begin
            addr_n = addr_from_core;
            cnt_n  = '0;
            if (bus_grant) begin
              tx_n    = addr_frame(addr_from_core);
              state_n = ADDR_TX;
            end else state_n = ARB;
          end else if (timer == HOLD_TIMEOUT - 8'd1) begin
            breq_n  = 1'b0;
            state_n = IDLE;
          end else timer_n = timer + 8'd1;
        end
        RETRY: begin
          breq_n  = 1'b1;
          state_n = ARB;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: write, read, forced burst, ack timeout, grant loss, mid-transfer reset.
module tb_master_port;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr_from_core;
  logic        write_addr_req_from_core;
  logic [7:0]  write_data_from_core;
  logic        write_data_req_from_core;
  logic        read_data_req_from_core;
  logic        force_req_from_core;
  logic        ok_response_to_core;
  logic [7:0]  read_data_to_core;
  logic        req_done_to_core;
  logic        bus_req;
  logic        bus_grant;
  logic        m_tx;
  logic        m_tx_valid;
  logic        s_ack;
  logic        s_rx;
  logic        s_rx_valid;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] v;
  logic [7:0]  rbyte;
  logic        mon_en = 1'b0;
  logic        breq_gap = 1'b0;

  master_port #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .ACK_TIMEOUT(8'd20), .HOLD_TIMEOUT(8'd8)) dut (
    .clk(clk), .reset(reset),
    .addr_from_core(addr_from_core),
    .write_addr_req_from_core(write_addr_req_from_core),
    .write_data_from_core(write_data_from_core),
    .write_data_req_from_core(write_data_req_from_core),
    .read_data_req_from_core(read_data_req_from_core),
    .force_req_from_core(force_req_from_core),
    .ok_response_to_core(ok_response_to_core),
    .read_data_to_core(read_data_to_core),
    .req_done_to_core(req_done_to_core),
    .bus_req(bus_req), .bus_grant(bus_grant),
    .m_tx(m_tx), .m_tx_valid(m_tx_valid),
    .s_ack(s_ack), .s_rx(s_rx), .s_rx_valid(s_rx_valid)
  );

  always #5 clk = ~clk;

  // Records any cycle where bus ownership is given up during the forced burst.
  always @(negedge clk) if (mon_en && !bus_req) breq_gap = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int n, input string tag, output logic [15:0] bits);
    int   k;
    logic allv;
    k = 0;
    bits = '0;
    allv = 1'b1;
    while (!m_tx_valid && k < 40) begin
      tick();
      k++;
    end
    for (int i = 0; i < n; i++) begin
      allv = allv & m_tx_valid;
      bits = {bits[14:0], m_tx};
      tick();
    end
    check({tag, "_valid"}, {31'd0, allv}, 32'd1);
  endtask

  task automatic ack_after(input int d);
    repeat (d - 1) tick();
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
  endtask

  task automatic addr_phase(input logic [15:0] a, input string tag);
    logic [15:0] bits;
    addr_from_core = a;
    write_addr_req_from_core = 1'b1;
    capture(16, tag, bits);
    check({tag, "_addr_frame"}, bits, a);
    check({tag, "_ok_pre"}, ok_response_to_core, 0);
    ack_after(2);
    check({tag, "_ok"}, ok_response_to_core, 1);
    write_addr_req_from_core = 1'b0;
    tick();
    check({tag, "_ok_clr"}, ok_response_to_core, 0);
  endtask

  task automatic wdata_phase(input logic [7:0] d, input string tag);
    logic [15:0] bits;
    write_data_from_core = d;
    write_data_req_from_core = 1'b1;
    capture(8, tag, bits);
    check({tag, "_data_frame"}, bits, {8'h00, d});
    check({tag, "_done_pre"}, req_done_to_core, 0);
    ack_after(2);
    check({tag, "_done"}, req_done_to_core, 1);
  endtask

  task automatic end_data(input string tag, input logic f);
    write_data_req_from_core = 1'b0;
    read_data_req_from_core = 1'b0;
    force_req_from_core = f;
    tick();
    force_req_from_core = 1'b0;
    check({tag, "_done_clr"}, req_done_to_core, 0);
    tick();
    check({tag, "_bus_req_after"}, bus_req, f);
  endtask

  initial begin
    reset = 1'b0;
    addr_from_core = '0;
    write_addr_req_from_core = 1'b0;
    write_data_from_core = '0;
    write_data_req_from_core = 1'b0;
    read_data_req_from_core = 1'b0;
    force_req_from_core = 1'b0;
    bus_grant = 1'b0;
    s_ack = 1'b0;
    s_rx = 1'b0;
    s_rx_valid = 1'b0;
    repeat (2) tick();
    check("rst_bus_req", bus_req, 0);
    check("rst_ok", ok_response_to_core, 0);
    check("rst_done", req_done_to_core, 0);
    check("rst_rdata", read_data_to_core, 0);
    check("rst_tx_valid", m_tx_valid, 0);
    check("rst_tx", m_tx, 0);
    reset = 1'b1;
    tick();

    // Single write, grant 3 cycles late
    addr_from_core = 16'hB190;
    write_addr_req_from_core = 1'b1;
    tick();
    check("t1_bus_req", bus_req, 1);
    repeat (2) tick();
    check("t1_arb_no_tx", m_tx_valid, 0);
    bus_grant = 1'b1;
    capture(16, "t1", v);
    check("t1_addr_frame", v, 16'hB190);
    ack_after(2);
    check("t1_ok", ok_response_to_core, 1);
    write_addr_req_from_core = 1'b0;
    tick();
    check("t1_ok_clr", ok_response_to_core, 0);
    wdata_phase(8'hAA, "t1");
    check("t1_bus_req_done", bus_req, 1);
    end_data("t1", 1'b0);
    check("t1_tx_idle", m_tx, 0);

    // Read with a discarded 3-bit partial byte
    addr_phase(16'hA190, "t2");
    read_data_req_from_core = 1'b1;
    tick();
    s_rx_valid = 1'b1;
    s_rx = 1'b1;
    repeat (3) tick();
    s_rx_valid = 1'b0;
    s_rx = 1'b0;
    tick();
    check("t2_no_early_done", req_done_to_core, 0);
    rbyte = 8'h9B;
    for (int i = 7; i >= 0; i--) begin
      s_rx_valid = 1'b1;
      s_rx = rbyte[i];
      tick();
    end
    s_rx_valid = 1'b0;
    s_rx = 1'b0;
    check("t2_done", req_done_to_core, 1);
    check("t2_rdata", read_data_to_core, 8'h9B);
    tick();
    check("t2_done_held", req_done_to_core, 1);
    end_data("t2", 1'b0);
    check("t2_rdata_kept", read_data_to_core, 8'h9B);

    // Burst with force: second frame must start straight from HOLD
    addr_phase(16'hD3E8, "t3a");
    mon_en = 1'b1;
    wdata_phase(8'h91, "t3a");
    end_data("t3a", 1'b1);
    addr_from_core = 16'hD3E9;
    write_addr_req_from_core = 1'b1;
    tick();
    check("t3_no_arb_wait", m_tx_valid, 1);
    addr_phase(16'hD3E9, "t3b");
    wdata_phase(8'h96, "t3b");
    end_data("t3b", 1'b0);
    mon_en = 1'b0;
    check("t3_bus_req_held", {31'd0, breq_gap}, 0);

    // Ack timeout: 20 cycles, one cycle of bus_req low, same frame again
    addr_from_core = 16'h8123;
    write_addr_req_from_core = 1'b1;
    capture(16, "t4_first", v);
    check("t4_first_frame", v, 16'h8123);
    repeat (19) tick();
    check("t4_pre_timeout", bus_req, 1);
    tick();
    check("t4_retry_drop", bus_req, 0);
    tick();
    check("t4_rearb", bus_req, 1);
    addr_phase(16'h8123, "t4");
    wdata_phase(8'h5C, "t4");
    end_data("t4", 1'b0);

    // Grant lost at bit 5, restored 4 cycles later
    addr_from_core = 16'hC3A5;
    write_addr_req_from_core = 1'b1;
    capture(5, "t5_part", v);
    check("t5_part_bits", v, 16'h0018);
    bus_grant = 1'b0;
    #1;
    check("t5_valid_drop", m_tx_valid, 0);
    tick();
    check("t5_arb_bus_req", bus_req, 1);
    repeat (3) tick();
    check("t5_arb_no_tx", m_tx_valid, 0);
    bus_grant = 1'b1;
    addr_phase(16'hC3A5, "t5");
    wdata_phase(8'h3C, "t5");
    end_data("t5", 1'b0);

    // Reset in the middle of the write data frame
    addr_phase(16'h1234, "t6");
    write_data_from_core = 8'hF0;
    write_data_req_from_core = 1'b1;
    repeat (3) tick();
    check("t6_mid_tx", m_tx_valid, 1);
    reset = 1'b0;
    #1;
    check("t6_rst_bus_req", bus_req, 0);
    check("t6_rst_tx_valid", m_tx_valid, 0);
    check("t6_rst_tx", m_tx, 0);
    check("t6_rst_rdata", read_data_to_core, 0);
    check("t6_rst_done", req_done_to_core, 0);
    write_data_req_from_core = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    addr_phase(16'h2345, "t6b");
    wdata_phase(8'h5A, "t6b");
    end_data("t6b", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
